alu_cmd_queue: RTL and testbench



---
 rtl/alu_cmd_queue.sv | 244 ++++++++++++++++++++++++
 tb/tb_alu_cmd_queue.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_queue.sv
// -----------------------------------------------------------------------------
// alu_cmd_queue
//
// Command front-end for the 8-bit ALU core. Operation requests (one-hot
// opcode + two operands) are buffered in a small FIFO and replayed to the ALU
// one at a time using its load/persist protocol. A fixed number of cycles
// after the load, the ALU result is captured and offered on a valid/ready
// result port together with the opcode that produced it.
//
// Parameters
//   DEPTH    command FIFO entries (power of two, >= 2)
//   ALU_LAT  cycles from the ALU load cycle to a valid alu_out (>= 1)
//
// Optional feature macro
//   ALU_CMD_ERRCHK_EN  when defined, commands whose opcode is not exactly
//                      one-hot are accepted but discarded, and cmd_err pulses
//                      for one cycle. When undefined, cmd_err is tied low.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-low reset
//   cmd_valid    producer offers a command
//   cmd_ready    queue can accept (combinational, = !full)
//   cmd_op       one-hot ALU operation
//   cmd_a/cmd_b  operands
//   cmd_err      one-cycle pulse when a malformed command is dropped
//   alu_on       ALU enable
//   alu_in_sel   ALU input select {persist, load, reset}
//   alu_num1/2   operands to the ALU
//   alu_out_sel  operation to the ALU
//   alu_out      ALU result
//   res_valid    a result is held
//   res_ready    consumer accepts the result
//   res_data     captured result
//   res_op       opcode that produced res_data
//   dbg_state    current FSM state (IDLE=0, ISSUE=1, WAIT=2, HOLD=3)
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid and ready are both high. The command producer may change cmd_* freely
// while cmd_valid is low; res_data/res_op stay frozen while res_valid is high
// and res_ready is low.
// -----------------------------------------------------------------------------
module alu_cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic       cmd_err,
  output logic       alu_on,
  output logic [2:0] alu_in_sel,
  output logic [7:0] alu_num1,
  output logic [7:0] alu_num2,
  output logic [6:0] alu_out_sel,
  input  logic [7:0] alu_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [6:0] res_op,
  output logic [1:0] dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [LW-1:0] LAT_INIT = LW'(ALU_LAT - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // ALU input-select encodings {persist, load, reset}
  localparam logic [2:0] SEL_RESET   = 3'b001;
  localparam logic [2:0] SEL_LOAD    = 3'b010;
  localparam logic [2:0] SEL_PERSIST = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic [6:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  state_t          state;
  cmd_t            mem [DEPTH];
  cmd_t            head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [LW-1:0]   lat_cnt;

  logic            full;
  logic            push_hs;
  logic            wr_en;
  logic            pop;
  logic            start_issue;

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  // cmd_ready depends only on the registered count, so a pop in the same
  // cycle never lets a full FIFO accept.
  assign full      = (count == FULL_CNT);
  assign cmd_ready = !full;
  assign push_hs   = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];

  // The head is popped on the edge that ends the ISSUE cycle; the ALU
  // operand registers already latched it on the edge that entered ISSUE.
  assign pop = (state == ISSUE);

`ifdef ALU_CMD_ERRCHK_EN
  function automatic logic is_onehot(input logic [6:0] v);
    return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
  endfunction

  // Malformed commands complete the handshake but are never written.
  assign wr_en = push_hs && is_onehot(cmd_op);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= push_hs && !is_onehot(cmd_op);
    end
  end
`else
  assign wr_en   = push_hs;
  assign cmd_err = 1'b0;
`endif

  // Storage has no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count disambiguates
  // full from empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  // A new command is issued from IDLE whenever the queue is non-empty, or
  // from HOLD in the same cycle the held result is taken. An untaken result
  // therefore blocks further issue.
  assign start_issue = (count != '0) &&
                       ((state == IDLE) || ((state == HOLD) && res_ready));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      alu_on      <= 1'b0;
      alu_in_sel  <= SEL_RESET;
      alu_num1    <= '0;
      alu_num2    <= '0;
      alu_out_sel <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_op      <= '0;
    end else begin
      alu_on <= 1'b1;

      case (state)
        IDLE: begin
          alu_in_sel <= SEL_PERSIST;
        end

        ISSUE: begin
          alu_in_sel <= SEL_PERSIST;
          lat_cnt    <= LAT_INIT;
          state      <= WAIT;
        end

        WAIT: begin
          alu_in_sel <= SEL_PERSIST;
          if (lat_cnt == '0) begin
            res_data  <= alu_out;
            res_op    <= alu_out_sel;
            res_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end

        HOLD: begin
          alu_in_sel <= SEL_PERSIST;
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          alu_in_sel <= SEL_PERSIST;
          state      <= IDLE;
        end
      endcase

      // Entering ISSUE overrides the per-state defaults above: the FIFO head
      // is presented to the ALU together with the load select.
      if (start_issue) begin
        state       <= ISSUE;
        alu_in_sel  <= SEL_LOAD;
        alu_num1    <= head.a;
        alu_num2    <= head.b;
        alu_out_sel <= head.op;
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_queue
//
// Directed bench for alu_cmd_queue. A small ALU model (out = a + b of the last
// loaded operands) sits on the ALU side. Stimulus pushes the expected
// {opcode, result} pair into exp_q; an independent monitor pops and compares
// on every accepted result. Cycle-exact checks on the ALU-side outputs are
// made by the stimulus thread itself, sampled #1 after each rising edge.
// -----------------------------------------------------------------------------
module tb_alu_cmd_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_op = '0;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic       cmd_err;
  logic       alu_on;
  logic [2:0] alu_in_sel;
  logic [7:0] alu_num1;
  logic [7:0] alu_num2;
  logic [6:0] alu_out_sel;
  logic [7:0] alu_out;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic [6:0] res_op;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [14:0] exp_q[$];
  int          res_cyc[$];

  alu_cmd_queue #(.DEPTH(4), .ALU_LAT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_err     (cmd_err),
    .alu_on      (alu_on),
    .alu_in_sel  (alu_in_sel),
    .alu_num1    (alu_num1),
    .alu_num2    (alu_num2),
    .alu_out_sel (alu_out_sel),
    .alu_out     (alu_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_op      (res_op),
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock and cycle counter
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // ---------------------------------------------------------------------------
  // ALU model: operands registered on a load, cleared on a reset select
  // ---------------------------------------------------------------------------
  logic [7:0] m_a = '0;
  logic [7:0] m_b = '0;

  always @(posedge clk) begin
    if (alu_in_sel == 3'b001) begin
      m_a <= '0;
      m_b <= '0;
    end else if (alu_in_sel == 3'b010) begin
      m_a <= alu_num1;
      m_b <= alu_num2;
    end
  end

  assign alu_out = m_a + m_b;

  // ---------------------------------------------------------------------------
  // Check helper and scoreboard monitor
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got op=0x%0h data=%0d, expected none",
                 res_op, res_data);
      end else begin
        check("result", 32'({res_op, res_data}), 32'(exp_q.pop_front()));
      end
      res_cyc.push_back(cyc);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one command; returns after the accepting edge with the number of
  // cycles spent waiting for cmd_ready.
  task automatic push(input logic [6:0] op, input logic [7:0] a,
                      input logic [7:0] b, input bit expect_res,
                      output int waited);
    logic [7:0] sum;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    waited    = 0;
    while (cmd_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got cmd_ready=%b, expected 1 within 50 cycles",
               cmd_ready);
    end else begin
      sum = a + b;
      if (expect_res) exp_q.push_back({op, sum});
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int w;
    int base;
    bit bad;

    // Reset values
    rst = 1'b0;
    repeat (2) tick();
    check("rst_in_sel",    32'(alu_in_sel), 32'h1);
    check("rst_alu_on",    32'(alu_on),     32'h0);
    check("rst_res_valid", 32'(res_valid),  32'h0);
    check("rst_cmd_ready", 32'(cmd_ready),  32'h1);
    check("rst_num1",      32'(alu_num1),   32'h0);
    check("rst_cmd_err",   32'(cmd_err),    32'h0);
    rst = 1'b1;
    tick();
    check("rel_in_sel", 32'(alu_in_sel), 32'h4);
    check("rel_alu_on", 32'(alu_on),     32'h1);

    // Single command: load visible after E1, result after E4
    push(7'b1000000, 8'd87, 8'd26, 1'b1, w);
    check("e0_in_sel", 32'(alu_in_sel), 32'h4);
    tick();
    check("e1_in_sel",  32'(alu_in_sel),  32'h2);
    check("e1_num1",    32'(alu_num1),    32'd87);
    check("e1_num2",    32'(alu_num2),    32'd26);
    check("e1_out_sel", 32'(alu_out_sel), 32'h40);
    tick();
    check("e2_in_sel", 32'(alu_in_sel), 32'h4);
    check("e2_num1",   32'(alu_num1),   32'd87);
    tick();
    check("e3_res_valid", 32'(res_valid), 32'h0);
    tick();
    check("e4_res_valid", 32'(res_valid), 32'h1);
    check("e4_res_data",  32'(res_data),  32'd113);
    check("e4_res_op",    32'(res_op),    32'h40);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("e5_res_valid", 32'(res_valid), 32'h0);
    repeat (2) tick();

    // Fill and back-pressure: five pushes accepted with no stall
    for (int i = 0; i < 5; i++) begin
      push(7'(7'd1 << i), 8'(10 * i + 1), 8'(i), 1'b1, w);
      check("fill_wait", 32'(w), 32'd0);
    end
    check("fill_ready_low", 32'(cmd_ready), 32'h0);
    repeat (8) tick();
    check("bp_res_valid", 32'(res_valid), 32'h1);
    check("bp_res_data",  32'(res_data),  32'd1);
    check("bp_state",     32'(dbg_state), 32'd3);
    check("bp_in_sel",    32'(alu_in_sel), 32'h4);
    check("bp_ready_low", 32'(cmd_ready), 32'h0);
    res_ready = 1'b1;
    drain(100);
    repeat (3) tick();
    check("fill_idle_ready", 32'(cmd_ready), 32'h1);

    // Ordering and back-to-back spacing with res_ready held high
    base = res_cyc.size();
    push(7'b0000001, 8'd2, 8'd4, 1'b1, w);
    push(7'b0000100, 8'd7, 8'd2, 1'b1, w);
    push(7'b0010000, 8'd1, 8'd1, 1'b1, w);
    drain(100);
    check("spacing_1", 32'(res_cyc[base + 1] - res_cyc[base]),     32'd4);
    check("spacing_2", 32'(res_cyc[base + 2] - res_cyc[base + 1]), 32'd4);
    res_ready = 1'b0;
    repeat (2) tick();

    // Reset mid-WAIT with two commands still queued
    push(7'b0000010, 8'd10, 8'd20, 1'b1, w);
    push(7'b0000010, 8'd30, 8'd40, 1'b1, w);
    push(7'b0000010, 8'd50, 8'd60, 1'b1, w);
    check("mid_state_wait", 32'(dbg_state), 32'd2);
    rst = 1'b0;
    tick();
    check("mrst_in_sel",    32'(alu_in_sel),  32'h1);
    check("mrst_alu_on",    32'(alu_on),      32'h0);
    check("mrst_res_valid", 32'(res_valid),   32'h0);
    check("mrst_num1",      32'(alu_num1),    32'h0);
    check("mrst_out_sel",   32'(alu_out_sel), 32'h0);
    check("mrst_res_data",  32'(res_data),    32'h0);
    check("mrst_res_op",    32'(res_op),      32'h0);
    check("mrst_cmd_ready", 32'(cmd_ready),   32'h1);
    rst = 1'b1;
    exp_q.delete();
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid !== 1'b0 || alu_in_sel !== 3'b100) bad = 1'b1;
    end
    check("no_issue_after_rst", 32'(bad), 32'h0);
    res_ready = 1'b1;
    push(7'b0001000, 8'd200, 8'd100, 1'b1, w);
    drain(50);

    // Malformed opcodes
`ifdef ALU_CMD_ERRCHK_EN
    push(7'b0000000, 8'd3, 8'd4, 1'b0, w);
    check("err_pulse_zero", 32'(cmd_err), 32'h1);
    tick();
    check("err_clear_zero", 32'(cmd_err), 32'h0);
    push(7'b0110000, 8'd5, 8'd6, 1'b0, w);
    check("err_pulse_two", 32'(cmd_err), 32'h1);
    tick();
    check("err_clear_two", 32'(cmd_err), 32'h0);
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (dbg_state !== 2'd0 || alu_in_sel !== 3'b100) bad = 1'b1;
    end
    check("err_no_issue", 32'(bad), 32'h0);
    check("err_ready",    32'(cmd_ready), 32'h1);
`else
    push(7'b0000000, 8'd3, 8'd4, 1'b1, w);
    check("noerr_pulse_zero", 32'(cmd_err), 32'h0);
    push(7'b0110000, 8'd5, 8'd6, 1'b1, w);
    check("noerr_pulse_two", 32'(cmd_err), 32'h0);
    drain(50);
`endif

    repeat (4) tick();
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
